// File: rtl/push_input_conditioner.sv
// push_input_conditioner: sync, debounce, edge-pulse and auto-repeat for buttons and switches
module push_input_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         REPEAT_DELAY    = 50_000_000,
  parameter int         REPEAT_RATE     = 10_000_000,
  parameter logic [4:0] REPEAT_MASK     = 5'b00011
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [4:0]  push_raw,
  input  logic [14:0] spdt_raw,
  output logic [4:0]  push_level,
  output logic [4:0]  push_pulse,
  output logic [14:0] spdt_level,
  output logic [14:0] spdt_change
);
  localparam int N    = 20;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = RMAX > 2 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;
  logic [N-1:0]  raw, q1_q, q2_q, stable_q, stable_dly_q, hit;
  logic [4:0]    rise, rep_fire, push_pulse_q;
  logic [14:0]   spdt_change_q;
  assign raw  = {spdt_raw, push_raw};
  assign rise = stable_q[4:0] & ~stable_dly_q[4:0];
  always_ff @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      q1_q          <= '0;
      q2_q          <= '0;
      stable_q      <= '0;
      stable_dly_q  <= '0;
      push_pulse_q  <= '0;
      spdt_change_q <= '0;
    end else begin
      q1_q          <= raw;
      q2_q          <= q1_q;
      stable_q      <= stable_q ^ hit;
      stable_dly_q  <= stable_q;
      push_pulse_q  <= rise | rep_fire;
      spdt_change_q <= stable_q[19:5] ^ stable_dly_q[19:5];
    end
  end
  // hit marks the cycle a mismatch has persisted long enough to be accepted
  for (genvar i = 0; i < N; i++) begin : g_db
    logic [DW-1:0] cnt_q;
    assign hit[i] = (q2_q[i] != stable_q[i]) && (cnt_q == DW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= (q2_q[i] == stable_q[i] || hit[i]) ? '0 : cnt_q + 1'b1;
    end
  end
  for (genvar i = 0; i < 5; i++) begin : g_rep
    if (REPEAT_MASK[i]) begin : g_on
      rep_state_e    state_q, state_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          fire;
      assign rep_fire[i] = fire;
      always_comb begin
        state_d = state_q;
        rcnt_d  = '0;
        fire    = 1'b0;
        if (!stable_q[i]) state_d = IDLE;
        else if (state_q == IDLE) state_d = rise[i] ? DELAY : IDLE;
        else if (rcnt_q == RW'(state_q == DELAY ? REPEAT_DELAY - 1 : REPEAT_RATE - 1)) begin
          fire    = 1'b1;
          state_d = REPEAT;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
          state_q <= IDLE;
          rcnt_q  <= '0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
        end
      end
    end else begin : g_off
      assign rep_fire[i] = 1'b0;
    end
  end
  assign push_level  = stable_q[4:0];
  assign spdt_level  = stable_q[19:5];
  assign push_pulse  = push_pulse_q;
  assign spdt_change = spdt_change_q;
endmodule

// File: tb/tb_push_input_conditioner.sv
// tb_push_input_conditioner: window-based reference model plus directed scenarios with literal expectations
module tb_push_input_conditioner;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam logic [4:0] MASK = 5'b00011;
  logic        clk_osc = 1'b0;
  logic        reset   = 1'b1;
  logic [4:0]  push_raw = '0;
  logic [14:0] spdt_raw = '0;
  logic [4:0]  push_level, push_pulse;
  logic [14:0] spdt_level, spdt_change;
  int checks = 0, failures = 0;
  push_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)) dut (
    .clk_osc(clk_osc), .reset(reset), .push_raw(push_raw), .spdt_raw(spdt_raw),
    .push_level(push_level), .push_pulse(push_pulse), .spdt_level(spdt_level), .spdt_change(spdt_change));
  always #5 clk_osc = ~clk_osc;
  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask
  // Model: a level flips once the last D synchronized samples all disagree with it
  logic [19:0] rh [0:4095];
  logic [19:0] m_st = '0, m_old1 = '0, old, older, nst;
  logic [4:0]  m_pp = '0;
  logic [14:0] m_sc = '0;
  int          press_t [5] = '{0, 0, 0, 0, 0};
  int          n = 0;
  bit          m_valid = 1'b0, all;
  always @(posedge clk_osc or posedge reset) begin
    if (reset) begin
      n = 0; m_st = '0; m_old1 = '0; m_pp = '0; m_sc = '0; m_valid = 1'b1;
    end else begin
      old   = m_st;
      older = m_old1;
      rh[n] = {spdt_raw, push_raw};
      nst   = old;
      for (int b = 0; b < 20; b++) begin
        all = (n >= D + 1);
        if (all) for (int k = 2; k <= D + 1; k++) if (rh[n-k][b] == old[b]) all = 1'b0;
        if (all) nst[b] = ~old[b];
      end
      for (int b = 0; b < 5; b++) begin
        if (old[b] && !older[b]) press_t[b] = n;
        m_pp[b] = (old[b] && !older[b]) ||
                  (MASK[b] && old[b] && (n - press_t[b]) >= RD && ((n - press_t[b] - RD) % RR) == 0);
      end
      m_sc   = old[19:5] ^ older[19:5];
      m_old1 = old;
      m_st   = nst;
      n++;
    end
  end
  always @(negedge clk_osc) begin
    if (!reset && m_valid) begin
      check("model_push_level", push_level, m_st[4:0]);
      check("model_push_pulse", push_pulse, m_pp);
      check("model_spdt_level", spdt_level, m_st[19:5]);
      check("model_spdt_change", spdt_change, m_sc);
    end
  end
  int cnt, cnt2;
  int times[$];
  int exp3[6] = '{7, 27, 35, 43, 51, 59};
  int exp6[3] = '{7, 27, 35};
  initial begin
    repeat (3) @(negedge clk_osc);
    check("rst_push_level", push_level, 0);
    check("rst_push_pulse", push_pulse, 0);
    check("rst_spdt_level", spdt_level, 0);
    check("rst_spdt_change", spdt_change, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_osc);
    // clean press on unmasked middle button
    push_raw[4] = 1'b1; cnt = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk_osc);
      if (j == 50) push_raw[4] = 1'b0;
      cnt += int'(push_pulse[4]);
      if (j == 5) check("s1_level_before", push_level[4], 0);
      if (j == 6) check("s1_level_after", push_level[4], 1);
      if (j == 7) check("s1_pulse_high", push_pulse[4], 1);
      if (j == 8) check("s1_pulse_low", push_pulse[4], 0);
    end
    check("s1_pulse_count", cnt, 1);
    // bounce shorter than the debounce window
    cnt = 0; cnt2 = 0;
    for (int j = 0; j < 30; j++) begin
      push_raw[2] = (j < 3) || (j >= 6 && j < 9);
      @(negedge clk_osc);
      cnt  += int'(push_level[2]);
      cnt2 += int'(push_pulse[2]);
    end
    check("s2_level_count", cnt, 0);
    check("s2_pulse_count", cnt2, 0);
    // auto-repeat on up, held 60 cycles
    push_raw[0] = 1'b1; times.delete();
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk_osc);
      if (j == 60) push_raw[0] = 1'b0;
      if (push_pulse[0]) times.push_back(j);
    end
    check("s3_pulse_count", times.size(), 6);
    for (int i = 0; i < 6 && i < times.size(); i++) check("s3_pulse_time", times[i], exp3[i]);
    // release during DELAY: no repeat
    push_raw[1] = 1'b1; cnt = 0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk_osc);
      if (j == 15) push_raw[1] = 1'b0;
      cnt += int'(push_pulse[1]);
    end
    check("s3_delay_release_count", cnt, 1);
    // switch both edges
    spdt_raw[12] = 1'b1; cnt = 0; cnt2 = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk_osc);
      if (j == 10) spdt_raw[12] = 1'b0;
      cnt  += int'(spdt_level[12]);
      cnt2 += int'(spdt_change[12]);
      if (j == 5) check("s4_level_before", spdt_level[12], 0);
      if (j == 6) check("s4_level_after", spdt_level[12], 1);
      if (j == 7) check("s4_change_rise", spdt_change[12], 1);
      if (j == 17) check("s4_change_fall", spdt_change[12], 1);
    end
    check("s4_level_cycles", cnt, 10);
    check("s4_change_count", cnt2, 2);
    // simultaneous edges
    push_raw[1] = 1'b1; spdt_raw[5] = 1'b1;
    repeat (7) @(negedge clk_osc);
    check("s5_push_pulse", push_pulse[1], 1);
    check("s5_spdt_change", spdt_change[5], 1);
    push_raw[1] = 1'b0; spdt_raw[5] = 1'b0;
    repeat (30) @(negedge clk_osc);
    // reset while repeating, button held through reset
    push_raw[1] = 1'b1;
    repeat (38) @(negedge clk_osc);
    check("s6_level_before", push_level[1], 1);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_push_level", push_level, 0);
    check("s6_rst_push_pulse", push_pulse, 0);
    check("s6_rst_spdt_level", spdt_level, 0);
    check("s6_rst_spdt_change", spdt_change, 0);
    repeat (3) @(negedge clk_osc);
    reset = 1'b0; times.delete();
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk_osc);
      if (push_pulse[1]) times.push_back(j);
    end
    check("s6_pulse_count", times.size(), 3);
    for (int i = 0; i < 3 && i < times.size(); i++) check("s6_pulse_time", times[i], exp6[i]);
    push_raw[1] = 1'b0;
    repeat (20) @(negedge clk_osc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
